alu_result_writeback: RTL and testbench

- Downstream consumer of the combinational alu block: accepts each ALU result with its status flags, commits it to an internal register file and a status register.
- Read ports supply the alu's operand1/operand2, with write bypass; status_q supplies the alu's statusIn.
- Two-result operations (multiply upper/lower, divide quotient/remainder) share the single write port and are serialised over two cycles.

---
 rtl/alu_result_writeback_if.sv | 37 +++
 rtl/alu_result_writeback.sv | 121 ++++++++++++
 tb/tb_alu_result_writeback.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_result_writeback_if.sv
// Result handshake between the combinational ALU and the writeback stage.
// The ALU side drives the master modport; the writeback stage uses slave.
interface alu_result_writeback_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned AW    = 3
);
    logic             in_valid;
    logic             in_ready;
    logic [AW-1:0]    in_rd;
    logic [WIDTH-1:0] in_lo;
    logic [WIDTH-1:0] in_hi;
    logic             in_dual;
    logic [3:0]       in_status;
    logic             in_status_en;

    modport master (
        output in_valid,
        output in_rd,
        output in_lo,
        output in_hi,
        output in_dual,
        output in_status,
        output in_status_en,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_rd,
        input  in_lo,
        input  in_hi,
        input  in_dual,
        input  in_status,
        input  in_status_en,
        output in_ready
    );
endinterface

// File: rtl/alu_result_writeback.sv
// ALU result writeback: commits results to a register file (reg 0 hardwired
// to zero) and a status register. Dual-result operations write lo on accept
// and hi on the following edge. Read ports bypass the write in flight.
module alu_result_writeback #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned AW    = 3,
    parameter int unsigned CNTW  = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    alu_result_writeback_if.slave in_bus,
    input  logic [AW-1:0]        rd_addr1,
    input  logic [AW-1:0]        rd_addr2,
    output logic [WIDTH-1:0]     rd_data1,
    output logic [WIDTH-1:0]     rd_data2,
    output logic [3:0]           status_q,
    output logic                 busy,
    output logic [CNTW-1:0]      retire_cnt
);

    localparam int unsigned NREGS = 1 << AW;

    typedef enum logic {
        IDLE   = 1'b0,
        SECOND = 1'b1
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] regs [NREGS];
    logic [WIDTH-1:0] hold_data;
    logic [AW-1:0]    hold_addr;

    logic             accept;
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [WIDTH-1:0] wr_data;

    // Ready is gated by rst_n so it reads 0 throughout reset.
    assign in_bus.in_ready = rst_n && (state == IDLE);
    assign accept          = in_bus.in_valid && in_bus.in_ready;

    // Select the single write port source: pending hi word in SECOND, else the accepted lo word.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        if (state == SECOND) begin
            wr_en   = 1'b1;
            wr_addr = hold_addr;
            wr_data = hold_data;
        end else if (accept) begin
            wr_en   = 1'b1;
            wr_addr = in_bus.in_rd;
            wr_data = in_bus.in_lo;
        end
    end

    // Read ports: zero register first, then same-cycle write bypass, then stored contents.
    always_comb begin
        rd_data1 = regs[rd_addr1];
        rd_data2 = regs[rd_addr2];
        if (rd_addr1 == '0) begin
            rd_data1 = '0;
        end else if (wr_en && (rd_addr1 == wr_addr)) begin
            rd_data1 = wr_data;
        end
        if (rd_addr2 == '0) begin
            rd_data2 = '0;
        end else if (wr_en && (rd_addr2 == wr_addr)) begin
            rd_data2 = wr_data;
        end
    end

    // Sequencer, register file, flags and retire counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            busy       <= 1'b0;
            hold_data  <= '0;
            hold_addr  <= '0;
            status_q   <= '0;
            retire_cnt <= '0;
            for (int unsigned i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            // Writes to register 0 are dropped, which also covers the wrapped hi write.
            if (wr_en && (wr_addr != '0)) begin
                regs[wr_addr] <= wr_data;
            end

            case (state)
                IDLE: begin
                    if (accept) begin
                        if (in_bus.in_status_en) begin
                            status_q <= in_bus.in_status;
                        end
                        if (in_bus.in_dual) begin
                            hold_data <= in_bus.in_hi;
                            hold_addr <= in_bus.in_rd + AW'(1);
                            state     <= SECOND;
                            busy      <= 1'b1;
                        end else begin
                            retire_cnt <= retire_cnt + CNTW'(1);
                        end
                    end
                end
                SECOND: begin
                    retire_cnt <= retire_cnt + CNTW'(1);
                    state      <= IDLE;
                    busy       <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_result_writeback.sv
// Self-checking bench for alu_result_writeback: table-driven operations with
// a commit scoreboard, plus hand-written back-to-back and reset-in-SECOND cases.
module tb_alu_result_writeback;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned AW    = 3;
    localparam int unsigned CNTW  = 16;
    localparam int unsigned NREGS = 1 << AW;

    logic             clk;
    logic             rst_n;
    logic [AW-1:0]    rd_addr1;
    logic [AW-1:0]    rd_addr2;
    logic [WIDTH-1:0] rd_data1;
    logic [WIDTH-1:0] rd_data2;
    logic [3:0]       status_q;
    logic             busy;
    logic [CNTW-1:0]  retire_cnt;

    alu_result_writeback_if #(.WIDTH(WIDTH), .AW(AW)) bus ();

    alu_result_writeback #(.WIDTH(WIDTH), .AW(AW), .CNTW(CNTW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_bus     (bus.slave),
        .rd_addr1   (rd_addr1),
        .rd_addr2   (rd_addr2),
        .rd_data1   (rd_data1),
        .rd_data2   (rd_data2),
        .status_q   (status_q),
        .busy       (busy),
        .retire_cnt (retire_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0]    rd;
        logic [WIDTH-1:0] lo;
        logic [WIDTH-1:0] hi;
        logic             dual;
        logic [3:0]       st;
        logic             sten;
    } vec_t;

    typedef struct {
        logic [AW-1:0]    addr;
        logic [WIDTH-1:0] data;
    } commit_t;

    vec_t             vecs [7];
    commit_t          sb [$];
    logic [WIDTH-1:0] exp_regs [NREGS];
    logic [3:0]       exp_status;
    logic [CNTW-1:0]  exp_cnt;
    int               checks;
    int               errors;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_write(input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
        commit_t c;
        if (a != '0) exp_regs[a] = d;
        c.addr = a;
        c.data = (a == '0) ? '0 : d;
        sb.push_back(c);
    endtask

    task automatic model_reset();
        for (int i = 0; i < int'(NREGS); i++) exp_regs[i] = '0;
        exp_status = '0;
        exp_cnt    = '0;
        sb.delete();
    endtask

    // Pop each committed write and confirm it through read port 1 (stage idle, no bypass).
    task automatic drain_scoreboard(input string tag);
        commit_t c;
        while (sb.size() > 0) begin
            c = sb.pop_front();
            rd_addr1 = c.addr;
            #1;
            // A later write to the same address supersedes this one.
            check({tag, "_commit"}, rd_data1, exp_regs[c.addr]);
        end
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (!bus.in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("ready_wait", bus.in_ready, 1'b1);
    endtask

    task automatic idle_bus();
        bus.in_valid     = 1'b0;
        bus.in_rd        = '0;
        bus.in_lo        = '0;
        bus.in_hi        = '0;
        bus.in_dual      = 1'b0;
        bus.in_status    = '0;
        bus.in_status_en = 1'b0;
    endtask

    // Present one operation, check the accept-cycle bypass, then track it to retirement.
    task automatic run_op(input vec_t v);
        logic [AW-1:0] hi_addr;
        wait_ready();
        bus.in_valid     = 1'b1;
        bus.in_rd        = v.rd;
        bus.in_lo        = v.lo;
        bus.in_hi        = v.hi;
        bus.in_dual      = v.dual;
        bus.in_status    = v.st;
        bus.in_status_en = v.sten;
        rd_addr1 = v.rd;
        rd_addr2 = v.rd;
        #1;
        check("bypass_lo_p1", rd_data1, (v.rd == '0) ? '0 : v.lo);
        check("bypass_lo_p2", rd_data2, (v.rd == '0) ? '0 : v.lo);
        @(negedge clk);
        idle_bus();
        model_write(v.rd, v.lo);
        if (v.sten) exp_status = v.st;
        if (v.dual) begin
            hi_addr  = v.rd + AW'(1);
            rd_addr1 = hi_addr;
            rd_addr2 = v.rd;
            #1;
            check("second_busy", busy, 1'b1);
            check("second_ready", bus.in_ready, 1'b0);
            check("bypass_hi", rd_data1, (hi_addr == '0) ? '0 : v.hi);
            check("lo_committed", rd_data2, (v.rd == '0) ? '0 : v.lo);
            check("cnt_hold", retire_cnt, exp_cnt);
            model_write(hi_addr, v.hi);
            @(negedge clk);
        end
        exp_cnt = exp_cnt + CNTW'(1);
        check("idle_busy", busy, 1'b0);
        check("idle_ready", bus.in_ready, 1'b1);
        check("status", status_q, exp_status);
        check("retire_cnt", retire_cnt, exp_cnt);
        drain_scoreboard("vec");
    endtask

    initial begin
        checks = 0;
        errors = 0;
        idle_bus();
        rd_addr1 = '0;
        rd_addr2 = '0;
        model_reset();

        vecs[0] = '{rd: 3'd2, lo: 32'd9,         hi: 32'd0,         dual: 1'b0, st: 4'b0000, sten: 1'b1};
        vecs[1] = '{rd: 3'd3, lo: 32'h0000_DEAD, hi: 32'd0,         dual: 1'b0, st: 4'b0100, sten: 1'b1};
        vecs[2] = '{rd: 3'd0, lo: 32'h1234_5678, hi: 32'd0,         dual: 1'b0, st: 4'b1111, sten: 1'b0};
        vecs[3] = '{rd: 3'd4, lo: 32'h0000_0001, hi: 32'hFFFF_FFFF, dual: 1'b1, st: 4'b1000, sten: 1'b1};
        vecs[4] = '{rd: 3'd7, lo: 32'h0000_00AA, hi: 32'h0000_0055, dual: 1'b1, st: 4'b0011, sten: 1'b0};
        vecs[5] = '{rd: 3'd1, lo: 32'h0000_0011, hi: 32'hCAFE_0000, dual: 1'b0, st: 4'b0010, sten: 1'b1};
        vecs[6] = '{rd: 3'd6, lo: 32'hA5A5_0006, hi: 32'h5A5A_0007, dual: 1'b1, st: 4'b0101, sten: 1'b1};

        // Reset state
        rst_n = 1'b0;
        #1;
        check("rst_ready", bus.in_ready, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_cnt", retire_cnt, '0);
        check("rst_status", status_q, 4'b0000);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post_rst_ready", bus.in_ready, 1'b1);

        for (int i = 0; i < 7; i++) run_op(vecs[i]);

        // Full register file against the model
        for (int a = 0; a < int'(NREGS); a++) begin
            rd_addr1 = AW'(a);
            #1;
            check("regfile", rd_data1, exp_regs[a]);
        end

        // Back-to-back single accepts on consecutive edges
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            bus.in_valid     = 1'b1;
            bus.in_dual      = 1'b0;
            bus.in_status_en = 1'b0;
            bus.in_rd        = AW'(k + 1);
            bus.in_lo        = 32'hB000_0000 + k;
            #1;
            check("b2b_ready", bus.in_ready, 1'b1);
            model_write(AW'(k + 1), 32'hB000_0000 + k);
            @(negedge clk);
        end
        idle_bus();
        exp_cnt = exp_cnt + CNTW'(3);
        #1;
        check("b2b_cnt", retire_cnt, exp_cnt);
        check("b2b_status", status_q, exp_status);
        drain_scoreboard("b2b");

        // Reset asserted while the hi write of a dual op is pending
        wait_ready();
        bus.in_valid = 1'b1;
        bus.in_dual  = 1'b1;
        bus.in_rd    = 3'd2;
        bus.in_lo    = 32'h0000_0066;
        bus.in_hi    = 32'h0000_0077;
        @(negedge clk);
        idle_bus();
        #1;
        check("pre_rst_busy", busy, 1'b1);
        rst_n = 1'b0;
        model_reset();
        #1;
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_ready", bus.in_ready, 1'b0);
        check("mid_rst_cnt", retire_cnt, '0);
        check("mid_rst_status", status_q, 4'b0000);
        for (int a = 0; a < int'(NREGS); a++) begin
            rd_addr1 = AW'(a);
            #1;
            check("mid_rst_reg", rd_data1, '0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rel_ready", bus.in_ready, 1'b1);
        @(negedge clk);
        rd_addr1 = 3'd3;
        rd_addr2 = 3'd2;
        #1;
        check("rel_hi_target", rd_data1, '0);
        check("rel_lo_target", rd_data2, '0);
        check("rel_busy", busy, 1'b0);
        check("rel_cnt", retire_cnt, exp_cnt);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
